uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver: the receive end of the serial link driven by uart_tx.
//  - Synchronises async rx, validates start bit, samples each bit at mid-period,
//    checks stop bit, presents a byte with a 1-cycle valid strobe.
//  - Sits between the board RX pin and the command/data parser.
// PARAMETERS
//  - CLK_FREQ  100_000_000  system clock frequency, Hz
//  - BAUD      115200       line rate, bit/s
//  - CPB       CLK_FREQ/BAUD (integer division; 868 at defaults)  clocks per bit, derived localparam
// PORTS
//  - clk        in   1  system clock, all logic on posedge
//  - rst        in   1  reset, synchronous, active-high
//  - rx         in   1  serial input, idle high, asynchronous to clk
//  - data       out  8  last received byte, LSB first on the wire; held until next byte
//  - valid      out  1  1-cycle strobe: data updated with a good frame
//  - busy       out  1  high from start-bit detect until return to IDLE
//  - frame_err  out  1  1-cycle strobe: stop bit sampled low
// BEHAVIOUR
//  - Reset: data=8'h00, valid=0, busy=0, frame_err=0, FSM=IDLE, sync flops=1, counters=0.
//    Reset asserted mid-frame aborts the frame at once; no strobe is emitted.
//  - rx passes through a 2-flop synchroniser (reset value 1); the FSM sees only rx_s.
//  - Bit counter cnt counts 0..CPB-1; bit index idx counts 0..7.
//  - IDLE: rx_s==0 -> START, cnt=0, busy=1.
//  - START: at cnt==CPB/2-1, if rx_s==0 -> DATA (cnt=0, idx=0), else -> IDLE (glitch,
//    busy=0, no strobe).
//  - DATA: at cnt==CPB-1, shift rx_s into shreg[7] (right shift, LSB first), idx++;
//    after idx 7 -> PARITY (macro on) or STOP.
//  - STOP: at cnt==CPB-1: rx_s==1 -> data<=shreg, valid=1 for 1 cycle, -> IDLE;
//    rx_s==0 -> frame_err=1 for 1 cycle, data unchanged, -> WAIT_IDLE.
//  - WAIT_IDLE: stays until rx_s==1, then -> IDLE (prevents treating a break as a start).
//  - busy=0 in IDLE only; new start bit accepted in the cycle after valid.
//  - Latency: valid rises CPB/2 + 9*CPB + 2..3 cycles after rx falls (at defaults:
//    8248 +/- 1 clocks).
//  - valid and frame_err never assert in the same cycle.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples bit 9 at cnt==CPB-1.
//    Adds output parity_err (1 bit, 1-cycle strobe, reset 0). On mismatch with even parity
//    of shreg, parity_err strobes at the stop-bit sample and valid is suppressed;
//    the STOP check still runs (frame_err has priority).
//  - Not defined: no PARITY state, no parity_err port, 8N1 only.
// STRUCTURE
//  - uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE as 3-bit
//    localparams), function calc_cpb(clk_freq, baud), UART_DATA_W=8; shared with uart_tx.
//  - Sub-module uart_rx_sync: 2-flop synchroniser, reset value 1. Rest stays flat.
// TESTING (CLK_FREQ=100 MHz, BAUD=115200, CPB=868; driven by uart_tx or a bit task)
//  - Send 8'h41 8N1 -> exactly one valid strobe, data==8'h41, frame_err never high, busy
//    returns to 0.
//  - rx low for 200 clocks then high -> no valid, no frame_err, busy low again by
//    clock 440.
//  - Send 8'h5A with stop bit low, rx high 3 bit times later -> frame_err strobe once,
//    data keeps previous value, no valid, next frame 8'hC3 received OK.
//  - Back-to-back 8'h55, 8'hAA with no idle gap -> two valid strobes, data 8'h55 then
//    8'hAA.
//  - Assert rst for 1 clock during bit 4 of 8'hFF -> all outputs at reset values,
//    no strobe; next byte 8'h0F received correctly.
//  - UART_RX_PARITY_EN: 8'h07 with parity bit 0 -> parity_err strobe, no valid;
//    with parity bit 1 -> valid, data==8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, clocks-per-bit helper and parity helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    START     = S_START,
    DATA      = S_DATA,
    PARITY    = S_PARITY,
    STOP      = S_STOP,
    WAIT_IDLE = S_WAIT_IDLE
  } rx_state_e;

  function automatic int calc_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus of the UART: serial input plus byte/strobe outputs.
// UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if;
  import uart_pkg::*;

  logic                   rx;
  logic [UART_DATA_W-1:0] data;
  logic                   valid;
  logic                   busy;
  logic                   frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err;

  modport master (input rx, output data, output valid, output busy, output frame_err,
                  output parity_err);
  modport slave  (output rx, input data, input valid, input busy, input frame_err,
                  input parity_err);
`else
  modport master (input rx, output data, output valid, output busy, output frame_err);
  modport slave  (output rx, input data, input valid, input busy, input frame_err);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_d;
  logic [1:0] ff_q;

  always_comb begin
    ff_d = {ff_q[0], async_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit check.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int CPB   = calc_cpb(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_s;

  rx_state_e              state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [2:0]             idx_d, idx_q;
  logic [UART_DATA_W-1:0] shreg_d, shreg_q;
  logic [UART_DATA_W-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   busy_d, busy_q;
  logic                   frame_err_d, frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_d, par_bit_q;
  logic                   parity_err_d, parity_err_q;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.rx),
    .sync_o  (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      // Start bit must still be low at its midpoint, otherwise it was a glitch.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          idx_d = 3'd0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          shreg_d = {rx_s, shreg_q[UART_DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_LAST) begin
          cnt_d     = CNT_ZERO;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
`endif
      end

      // Frame error outranks parity error; either one suppresses the data update.
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bit_q != even_parity(shreg_q)) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        cnt_d = CNT_ZERO;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
